// File: rtl/sync_fifo_flags_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo_flags_if : write/read handshake and status bundle for sync_fifo_flags
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface sync_fifo_flags_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, rd_en, clr_err, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, clr_err, data_in,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo_flags : single-clock FIFO with thresholds, sticky errors, FWFT option
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module sync_fifo_flags #(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  wire logic          clk,
  input  wire logic          rst,
  sync_fifo_flags_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;

  // Gating uses the registered flags, so a full FIFO rejects a write even
  // when a read frees a slot on the same edge (and symmetrically for empty).
  always_comb begin
    wr_acc   = bus.wr_en & ~full_q;
    rd_acc   = bus.rd_en & ~empty_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CNT_W'(1);
    end
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CNT_W'(AF_LEVEL));
    aempty_d = (count_d <= CNT_W'(AE_LEVEL));
    // Set wins over a simultaneous clear.
    ovf_d    = (bus.wr_en & full_q)  | (ovf_q & ~bus.clr_err);
    unf_d    = (bus.rd_en & empty_q) | (unf_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      always_comb begin
        bus.data_out = empty_q ? '0 : mem_q[rd_ptr_q];
      end
    end else begin : g_reg_read
      logic [DATA_W-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = rd_acc ? mem_q[rd_ptr_q] : dout_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
        end else begin
          dout_q <= dout_d;
        end
      end

      always_comb begin
        bus.data_out = dout_q;
      end
    end
  endgenerate

  always_comb begin
    bus.full         = full_q;
    bus.empty        = empty_q;
    bus.almost_full  = afull_q;
    bus.almost_empty = aempty_q;
    bus.count        = count_q;
    bus.overflow     = ovf_q;
    bus.underflow    = unf_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sync_fifo_flags : scoreboard bench for registered-read and FWFT FIFO builds
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_sync_fifo_flags;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [3:0] sb [$];
  logic [3:0] exp_d;

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_W(4), .DEPTH(8)) bus0 ();
  sync_fifo_flags_if #(.DATA_W(4), .DEPTH(8)) bus1 ();

  sync_fifo_flags #(.DATA_W(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  sync_fifo_flags #(.DATA_W(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b1)) dut_fw (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.clr_err = 1'b0; bus0.data_in = '0;
    bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.clr_err = 1'b0; bus1.data_in = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    checks++; if (bus0.count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", bus0.count); end
    checks++; if ({bus0.empty, bus0.full, bus0.almost_empty, bus0.almost_full} !== 4'b1010) begin
      errors++; $display("FAIL rst_flags got=%b exp=1010", {bus0.empty, bus0.full, bus0.almost_empty, bus0.almost_full}); end
    checks++; if ({bus0.overflow, bus0.underflow} !== 2'b00) begin
      errors++; $display("FAIL rst_err got=%b exp=00", {bus0.overflow, bus0.underflow}); end
    checks++; if (bus0.data_out !== 4'h0 || bus1.data_out !== 4'h0) begin
      errors++; $display("FAIL rst_dout got=%h/%h exp=0/0", bus0.data_out, bus1.data_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      bus0.wr_en = 1'b1; bus0.data_in = 4'(i);
      sb.push_back(4'(i));
      tick();
      checks++; if (bus0.count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus0.count, i + 1); end
      checks++; if (bus0.almost_full !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, bus0.almost_full, (i + 1 >= 6)); end
      checks++; if (bus0.full !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, bus0.full, (i == 7)); end
      checks++; if (bus0.empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, bus0.empty); end
      checks++; if (bus0.almost_empty !== (i + 1 <= 2)) begin errors++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, bus0.almost_empty, (i + 1 <= 2)); end
    end
    bus0.wr_en = 1'b0;
  endtask

  task automatic test_overflow_drain();
    bus0.wr_en = 1'b1; bus0.data_in = 4'hF;
    tick();
    bus0.wr_en = 1'b0;
    checks++; if (bus0.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", bus0.overflow); end
    checks++; if (bus0.count !== 4'd8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", bus0.count); end
    for (int i = 0; i < 8; i++) begin
      bus0.rd_en = 1'b1;
      tick();
      exp_d = sb.pop_front();
      checks++; if (bus0.data_out !== exp_d) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, bus0.data_out, exp_d); end
      checks++; if (bus0.count !== 4'(7 - i)) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, bus0.count, 7 - i); end
    end
    bus0.rd_en = 1'b0;
    checks++; if ({bus0.empty, bus0.almost_empty, bus0.overflow} !== 3'b111) begin
      errors++; $display("FAIL drain_end got=%b exp=111", {bus0.empty, bus0.almost_empty, bus0.overflow}); end
  endtask

  task automatic test_underflow_clr();
    bus0.rd_en = 1'b1;
    tick();
    bus0.rd_en = 1'b0;
    checks++; if (bus0.underflow !== 1'b1) begin errors++; $display("FAIL unf_set got=%b exp=1", bus0.underflow); end
    checks++; if (bus0.data_out !== 4'h7) begin errors++; $display("FAIL unf_hold got=%h exp=7", bus0.data_out); end
    checks++; if (bus0.count !== 4'd0) begin errors++; $display("FAIL unf_count got=%0d exp=0", bus0.count); end
    bus0.clr_err = 1'b1;
    tick();
    checks++; if ({bus0.overflow, bus0.underflow} !== 2'b00) begin
      errors++; $display("FAIL clr_err got=%b exp=00", {bus0.overflow, bus0.underflow}); end
    bus0.rd_en = 1'b1;
    tick();
    bus0.rd_en = 1'b0;
    checks++; if (bus0.underflow !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", bus0.underflow); end
    tick();
    bus0.clr_err = 1'b0;
    checks++; if (bus0.underflow !== 1'b0) begin errors++; $display("FAIL clr_again got=%b exp=0", bus0.underflow); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      bus0.wr_en = 1'b1; bus0.data_in = 4'(i + 1); sb.push_back(4'(i + 1));
      tick();
    end
    bus0.wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus0.rd_en = 1'b1;
      tick();
      exp_d = sb.pop_front();
      checks++; if (bus0.data_out !== exp_d) begin errors++; $display("FAIL wrap_rd1[%0d] got=%h exp=%h", i, bus0.data_out, exp_d); end
    end
    bus0.rd_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus0.wr_en = 1'b1; bus0.data_in = 4'(10 + i); sb.push_back(4'(10 + i));
      tick();
    end
    bus0.wr_en = 1'b0;
    checks++; if (bus0.count !== 4'd6) begin errors++; $display("FAIL wrap_count got=%0d exp=6", bus0.count); end
    for (int i = 0; i < 4; i++) begin
      bus0.wr_en = 1'b1; bus0.rd_en = 1'b1; bus0.data_in = 4'(i); sb.push_back(4'(i));
      tick();
      exp_d = sb.pop_front();
      checks++; if (bus0.data_out !== exp_d) begin errors++; $display("FAIL simul_data[%0d] got=%h exp=%h", i, bus0.data_out, exp_d); end
      checks++; if (bus0.count !== 4'd6) begin errors++; $display("FAIL simul_count[%0d] got=%0d exp=6", i, bus0.count); end
    end
    bus0.wr_en = 1'b0;
    while (sb.size() > 0) begin
      bus0.rd_en = 1'b1;
      tick();
      exp_d = sb.pop_front();
      checks++; if (bus0.data_out !== exp_d) begin errors++; $display("FAIL wrap_tail got=%h exp=%h", bus0.data_out, exp_d); end
    end
    bus0.rd_en = 1'b0;
    checks++; if (bus0.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", bus0.empty); end
  endtask

  task automatic test_fwft();
    checks++; if (bus1.data_out !== 4'h0 || bus1.empty !== 1'b1) begin
      errors++; $display("FAIL fwft_idle got=%h/%b exp=0/1", bus1.data_out, bus1.empty); end
    bus1.wr_en = 1'b1; bus1.data_in = 4'h9;
    tick();
    bus1.wr_en = 1'b0;
    checks++; if (bus1.data_out !== 4'h9 || bus1.empty !== 1'b0) begin
      errors++; $display("FAIL fwft_show got=%h/%b exp=9/0", bus1.data_out, bus1.empty); end
    bus1.rd_en = 1'b1;
    tick();
    bus1.rd_en = 1'b0;
    checks++; if (bus1.data_out !== 4'h0 || bus1.empty !== 1'b1) begin
      errors++; $display("FAIL fwft_pop got=%h/%b exp=0/1", bus1.data_out, bus1.empty); end
    for (int i = 0; i < 2; i++) begin
      bus1.wr_en = 1'b1; bus1.data_in = 4'(3 + i); sb.push_back(4'(3 + i));
      tick();
    end
    bus1.wr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_d = sb.pop_front();
      checks++; if (bus1.data_out !== exp_d) begin errors++; $display("FAIL fwft_order[%0d] got=%h exp=%h", i, bus1.data_out, exp_d); end
      bus1.rd_en = 1'b1;
      tick();
      bus1.rd_en = 1'b0;
    end
    checks++; if (bus1.data_out !== 4'h0 || bus1.empty !== 1'b1) begin
      errors++; $display("FAIL fwft_drained got=%h/%b exp=0/1", bus1.data_out, bus1.empty); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      bus0.wr_en = 1'b1; bus0.data_in = 4'(i + 1);
      tick();
    end
    bus0.wr_en = 1'b0;
    bus0.rd_en = 1'b1;   // drives underflow-free read; leaves count at 4 then refill
    bus0.wr_en = 1'b1; bus0.data_in = 4'h6;
    tick();
    idle();
    checks++; if (bus0.count !== 4'd5) begin errors++; $display("FAIL pre_rst_count got=%0d exp=5", bus0.count); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus0.count !== 4'd0) begin errors++; $display("FAIL arst_count got=%0d exp=0", bus0.count); end
    checks++; if ({bus0.empty, bus0.full, bus0.almost_empty, bus0.almost_full, bus0.overflow, bus0.underflow} !== 6'b101000) begin
      errors++; $display("FAIL arst_flags got=%b exp=101000",
        {bus0.empty, bus0.full, bus0.almost_empty, bus0.almost_full, bus0.overflow, bus0.underflow}); end
    checks++; if (bus0.data_out !== 4'h0) begin errors++; $display("FAIL arst_dout got=%h exp=0", bus0.data_out); end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    bus0.wr_en = 1'b1; bus0.data_in = 4'hC; sb.push_back(4'hC);
    tick();
    bus0.wr_en = 1'b0;
    checks++; if (bus0.count !== 4'd1) begin errors++; $display("FAIL post_rst_count got=%0d exp=1", bus0.count); end
    bus0.rd_en = 1'b1;
    tick();
    bus0.rd_en = 1'b0;
    exp_d = sb.pop_front();
    checks++; if (bus0.data_out !== exp_d || bus0.empty !== 1'b1) begin
      errors++; $display("FAIL post_rst_read got=%h/%b exp=%h/1", bus0.data_out, bus0.empty, exp_d); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow_clr();
    test_wrap();
    test_fwft();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
